bp_lce_req_arbiter: RTL

Two-into-one arbiter for the outbound LCE request network port. It sits between the instruction-side LCE request engine (port 0, fetch misses and uncached loads) and a second LCE request source (port 1, e.g. prefetch or uncached store engine), both driving the same LCE-to-CCE request channel. Port 0 has fixed priority. Port 1 has an anti-starvation counter that forces it a slot after a bounded wait. A one-entry output register decouples the sources from network backpressure while sustaining one message per cycle.

---
 rtl/bp_lce_req_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/bp_lce_req_arbiter.sv
// Two-into-one LCE request arbiter: fixed priority for port 0, anti-starvation
// promotion for port 1, and a one-entry output register toward the network.
module bp_lce_req_arbiter #(
  parameter int msg_width_p    = 128,
  parameter int starve_limit_p = 4
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [msg_width_p-1:0] req0_i,
  input  logic                   req0_v_i,
  output logic                   req0_ready_o,
  input  logic [msg_width_p-1:0] req1_i,
  input  logic                   req1_v_i,
  output logic                   req1_ready_o,
  output logic [msg_width_p-1:0] lce_req_o,
  output logic                   lce_req_v_o,
  input  logic                   lce_req_ready_i,
  output logic                   grant_id_o,
  output logic                   busy_o
);

  localparam int cnt_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [cnt_width_lp-1:0] starve_limit_lp = cnt_width_lp'(starve_limit_p);

  localparam logic [0:0] e_empty = 1'b0;
  localparam logic [0:0] e_full  = 1'b1;

  logic [0:0]              state_r;
  logic [0:0]              state_next_s;
  logic [cnt_width_lp-1:0] wait1_cnt_r;
  logic [cnt_width_lp-1:0] wait1_cnt_next_s;
  logic [msg_width_p-1:0]  lce_req_r;
  logic                    grant_id_r;

  logic space_s;
  logic starved_s;
  logic grant0_s;
  logic grant1_s;
  logic accept0_s;
  logic accept1_s;
  logic accept_s;

  // Arbitration: port 1 wins when port 0 is idle or port 1 has waited too long.
  always_comb begin
    space_s   = (state_r == e_empty) | lce_req_ready_i;
    starved_s = (wait1_cnt_r == starve_limit_lp);
    grant1_s  = req1_v_i & (~req0_v_i | starved_s);
    grant0_s  = req0_v_i & ~grant1_s;
    accept1_s = grant1_s & space_s;
    accept0_s = grant0_s & space_s;
    accept_s  = accept0_s | accept1_s;
  end

  // Buffer occupancy: a drain and an accept in the same cycle keep it full.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      e_empty: begin
        if (accept_s) state_next_s = e_full;
        else          state_next_s = e_empty;
      end
      e_full: begin
        if (lce_req_ready_i & ~accept_s) state_next_s = e_empty;
        else                             state_next_s = e_full;
      end
      default: state_next_s = e_empty;
    endcase
  end

  // Port 1 wait counter keeps counting through network stalls, saturating at the limit.
  always_comb begin
    wait1_cnt_next_s = '0;
    if (req1_v_i & ~accept1_s) begin
      if (starved_s) wait1_cnt_next_s = wait1_cnt_r;
      else           wait1_cnt_next_s = wait1_cnt_r + cnt_width_lp'(1);
    end else begin
      wait1_cnt_next_s = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_empty;
      wait1_cnt_r <= '0;
    end else begin
      state_r     <= state_next_s;
      wait1_cnt_r <= wait1_cnt_next_s;
    end
  end

  // Output message register: loads only on accept, so it holds while stalled.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      lce_req_r  <= '0;
      grant_id_r <= 1'b0;
    end else if (accept_s) begin
      lce_req_r  <= accept1_s ? req1_i : req0_i;
      grant_id_r <= accept1_s;
    end
  end

  assign req0_ready_o = space_s & ~(req1_v_i & starved_s);
  assign req1_ready_o = space_s & (~req0_v_i | starved_s);
  assign lce_req_o    = lce_req_r;
  assign grant_id_o   = grant_id_r;
  assign lce_req_v_o  = (state_r == e_full);
  assign busy_o       = (state_r == e_full) | req0_v_i | req1_v_i;

endmodule
